// File: rtl/vpu_mem_arbiter.sv
// vpu_mem_arbiter: shares one single-port 16K x 16-bit video RAM between
// scanout word fetches and CPU nibble-pair reads and writes.
//
// Handshakes:
//   cpu_wr: an entry is pushed on any cycle where cpu_wr_valid && cpu_wr_ready.
//           cpu_wr_ready depends only on registered FIFO state.
//   cpu_rd: a read is accepted on any cycle where cpu_rd_req && cpu_rd_ready.
//           The result is returned as a one-cycle cpu_rd_valid pulse.
//   vid:    there is no backpressure. vid_req is granted in the same cycle,
//           and vid_valid follows one cycle later.
//
// Memory op priority: video, then the second half of a split op, then the
// accepted read, then the write at the FIFO head.
module vpu_mem_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic        vid_valid,
  output logic [15:0] vid_data,
  input  logic        cpu_wr_valid,
  output logic        cpu_wr_ready,
  input  logic [15:0] cpu_wr_addr,
  input  logic [7:0]  cpu_wr_data,
  input  logic        cpu_rd_req,
  output logic        cpu_rd_ready,
  input  logic [15:0] cpu_rd_addr,
  output logic        cpu_rd_valid,
  output logic [7:0]  cpu_rd_data,
  output logic [13:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [2:0]  state_dbg
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_B    = 3'd1,
    ST_RD_A    = 3'd2,
    ST_RD_B    = 3'd3,
    ST_RD_WAIT = 3'd4
  } state_t;

  state_t      state_q, state_d;

  // Write queue: pointers carry one extra wrap bit to tell full from empty.
  logic [15:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]  fifo_data [FIFO_DEPTH];
  logic [PW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_empty, fifo_full, push, pop;

  logic [15:0] head_addr;
  logic [7:0]  head_data;
  logic [13:0] head_word;
  logic [1:0]  head_nib;
  logic [15:0] head_wdata;
  logic [3:0]  head_wmask;

  logic [15:0] rd_addr_q;
  logic [3:0]  rd_hi_q;
  logic        rd_a_cap_q;
  logic        rd_accept, rd_split_a_issue;
  logic [15:0] rd_shift;

  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign cpu_wr_ready = !fifo_full;
  assign push         = cpu_wr_valid && cpu_wr_ready;

  assign cpu_rd_ready = (state_q == ST_IDLE) && fifo_empty;
  assign rd_accept    = cpu_rd_req && cpu_rd_ready;

  assign head_addr  = fifo_addr[rd_ptr_q[PW-1:0]];
  assign head_data  = fifo_data[rd_ptr_q[PW-1:0]];
  assign head_word  = head_addr[15:2];
  assign head_nib   = head_addr[1:0];
  // Nibble k sits at bits [15-4k:12-4k]. Shifting the byte down by 4k
  // places both nibbles. For k=3 only the high nibble stays in the word,
  // which is exactly op A of a split write.
  assign head_wdata = {head_data, 8'h00} >> {head_nib, 2'b00};
  assign head_wmask = 4'b1100 >> head_nib;

  assign rd_shift   = mem_rdata << {rd_addr_q[1:0], 2'b00};

  assign vid_data   = mem_rdata;
  assign state_dbg  = state_q;

  // Next state, memory op selection and FIFO pop.
  always_comb begin
    state_d          = state_q;
    mem_addr         = 14'd0;
    mem_we           = 1'b0;
    mem_wmask        = 4'b0000;
    mem_wdata        = 16'h0000;
    pop              = 1'b0;
    rd_split_a_issue = 1'b0;
    if (vid_req) begin
      mem_addr = vid_addr;
    end
    case (state_q)
      ST_IDLE: begin
        if (rd_accept) begin
          state_d = ST_RD_A;
        end else if (!vid_req && !fifo_empty) begin
          mem_addr  = head_word;
          mem_we    = 1'b1;
          mem_wmask = head_wmask;
          mem_wdata = head_wdata;
          if (head_nib == 2'd3) begin
            state_d = ST_WR_B;
          end else begin
            pop = 1'b1;
          end
        end
      end
      ST_WR_B: begin
        if (!vid_req) begin
          mem_addr  = head_word + 14'd1;
          mem_we    = 1'b1;
          mem_wmask = 4'b1000;
          mem_wdata = {head_data[3:0], 12'h000};
          pop       = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_RD_A: begin
        if (!vid_req) begin
          mem_addr = rd_addr_q[15:2];
          if (rd_addr_q[1:0] == 2'd3) begin
            rd_split_a_issue = 1'b1;
            state_d          = ST_RD_B;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_B: begin
        if (!vid_req) begin
          mem_addr = rd_addr_q[15:2] + 14'd1;
          state_d  = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        // No op is issued here, so video cannot stall this state.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, queue pointers and read-side control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_addr_q  <= 16'h0000;
      rd_a_cap_q <= 1'b0;
      vid_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (rd_accept) rd_addr_q <= cpu_rd_addr;
      rd_a_cap_q <= rd_split_a_issue;
      vid_valid  <= vid_req;
    end
  end

  // Read result: holds the high nibble of a split read, then assembles the byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_hi_q      <= 4'h0;
      cpu_rd_valid <= 1'b0;
      cpu_rd_data  <= 8'h00;
    end else begin
      if (rd_a_cap_q) rd_hi_q <= mem_rdata[3:0];
      cpu_rd_valid <= (state_q == ST_RD_WAIT);
      if (state_q == ST_RD_WAIT) begin
        if (rd_addr_q[1:0] == 2'd3) begin
          cpu_rd_data <= {rd_hi_q, mem_rdata[15:12]};
        end else begin
          cpu_rd_data <= rd_shift[15:8];
        end
      end
    end
  end

  // Queue storage needs no reset because the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q[PW-1:0]] <= cpu_wr_addr;
      fifo_data[wr_ptr_q[PW-1:0]] <= cpu_wr_data;
    end
  end

endmodule

// File: tb/tb_vpu_mem_arbiter.sv
// Directed testbench for vpu_mem_arbiter, driving it against a behavioural
// single-port RAM with a registered read.
module tb_vpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vid_req;
  logic [13:0] vid_addr;
  logic        vid_valid;
  logic [15:0] vid_data;
  logic        cpu_wr_valid;
  logic        cpu_wr_ready;
  logic [15:0] cpu_wr_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_rd_req;
  logic        cpu_rd_ready;
  logic [15:0] cpu_rd_addr;
  logic        cpu_rd_valid;
  logic [7:0]  cpu_rd_data;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [2:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] ram [16384];

  vpu_mem_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .vid_req      (vid_req),
    .vid_addr     (vid_addr),
    .vid_valid    (vid_valid),
    .vid_data     (vid_data),
    .cpu_wr_valid (cpu_wr_valid),
    .cpu_wr_ready (cpu_wr_ready),
    .cpu_wr_addr  (cpu_wr_addr),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_rd_req   (cpu_rd_req),
    .cpu_rd_ready (cpu_rd_ready),
    .cpu_rd_addr  (cpu_rd_addr),
    .cpu_rd_valid (cpu_rd_valid),
    .cpu_rd_data  (cpu_rd_data),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wmask    (mem_wmask),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .state_dbg    (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // RAM model: nibble-masked write, read data registered one cycle.
  always @(posedge clk) begin
    if (mem_we) begin
      for (int n = 0; n < 4; n++) begin
        if (mem_wmask[n]) ram[mem_addr][n*4 +: 4] <= mem_wdata[n*4 +: 4];
      end
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = a;
    cpu_wr_data  = d;
    step();
    cpu_wr_valid = 1'b0;
    #1;
  endtask

  task automatic op(input string tag, input logic [13:0] a, input logic [3:0] m,
                    input logic [15:0] d);
    chk({tag, "_we"}, mem_we, 1'b1);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_mask"}, mem_wmask, m);
    chk({tag, "_wdata"}, mem_wdata, d);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 16'h0000;
    ram[14'h100] = 16'hA100;
    ram[14'h101] = 16'hA101;
    ram[14'h102] = 16'hA102;
    mem_rdata    = 16'h0000;
    reset        = 1'b1;
    vid_req      = 1'b0;
    vid_addr     = 14'h0;
    cpu_wr_valid = 1'b0;
    cpu_wr_addr  = 16'h0;
    cpu_wr_data  = 8'h0;
    cpu_rd_req   = 1'b0;
    cpu_rd_addr  = 16'h0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_vid_valid", vid_valid, 1'b0);
    chk("rst_rd_valid", cpu_rd_valid, 1'b0);
    chk("rst_rd_data", cpu_rd_data, 8'h00);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_wr_ready", cpu_wr_ready, 1'b1);
    chk("rst_rd_ready", cpu_rd_ready, 1'b1);

    // Aligned write
    cpu_wr_valid = 1'b1; cpu_wr_addr = 16'h0010; cpu_wr_data = 8'hAB;
    #1;
    chk("al_ready", cpu_wr_ready, 1'b1);
    step();
    cpu_wr_valid = 1'b0;
    #1;
    op("al", 14'h0004, 4'b1100, 16'hAB00);
    step();
    chk("al_after_we", mem_we, 1'b0);
    chk("al_empty", cpu_rd_ready, 1'b1);

    // Split writes, including address wrap
    wr(16'h0007, 8'h5C);
    op("sp1A", 14'h0001, 4'b0001, 16'h0005);
    step();
    chk("sp1_state", state_dbg, 3'd1);
    op("sp1B", 14'h0002, 4'b1000, 16'hC000);
    step();
    chk("sp1_done_we", mem_we, 1'b0);
    wr(16'hFFFF, 8'h12);
    op("sp2A", 14'h3FFF, 4'b0001, 16'h0001);
    step();
    op("sp2B", 14'h0000, 4'b1000, 16'h2000);
    step();

    // Video priority over two queued writes
    vid_req = 1'b1; vid_addr = 14'h100;
    cpu_wr_valid = 1'b1; cpu_wr_addr = 16'h0020; cpu_wr_data = 8'h11;
    #1;
    chk("v0_we", mem_we, 1'b0);
    chk("v0_addr", mem_addr, 14'h100);
    step();
    vid_addr = 14'h101; cpu_wr_addr = 16'h0024; cpu_wr_data = 8'h22;
    #1;
    chk("v1_we", mem_we, 1'b0);
    chk("v1_addr", mem_addr, 14'h101);
    chk("v1_vvalid", vid_valid, 1'b1);
    chk("v1_vdata", vid_data, 16'hA100);
    step();
    cpu_wr_valid = 1'b0; vid_addr = 14'h102;
    #1;
    chk("v2_we", mem_we, 1'b0);
    chk("v2_vdata", vid_data, 16'hA101);
    step();
    vid_req = 1'b0;
    #1;
    chk("v3_vvalid", vid_valid, 1'b1);
    chk("v3_vdata", vid_data, 16'hA102);
    op("v3", 14'h0008, 4'b1100, 16'h1100);
    step();
    chk("v4_vvalid", vid_valid, 1'b0);
    op("v4", 14'h0009, 4'b1100, 16'h2200);
    step();
    chk("v5_we", mem_we, 1'b0);

    // Video between split halves
    wr(16'h0013, 8'h77);
    op("vsA", 14'h0004, 4'b0001, 16'h0007);
    step();
    vid_req = 1'b1; vid_addr = 14'h103;
    #1;
    chk("vs_stall_we", mem_we, 1'b0);
    chk("vs_stall_addr", mem_addr, 14'h103);
    chk("vs_stall_state", state_dbg, 3'd1);
    step();
    vid_req = 1'b0;
    #1;
    op("vsB", 14'h0005, 4'b1000, 16'h7000);
    step();
    chk("vs_done_we", mem_we, 1'b0);

    // FIFO full while video holds the RAM
    vid_req = 1'b1; vid_addr = 14'h104;
    for (int i = 0; i < 4; i++) begin
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = 16'h0040 + 16'(i * 4);
      cpu_wr_data  = 8'(i + 1);
      #1;
      chk("ff_ready_in", cpu_wr_ready, 1'b1);
      step();
    end
    chk("ff_full", cpu_wr_ready, 1'b0);
    cpu_wr_addr = 16'h0050; cpu_wr_data = 8'h05;
    step();
    cpu_wr_valid = 1'b0;
    vid_req = 1'b0;
    #1;
    chk("ff_still_full", cpu_wr_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      op("ff_drain", 14'h0010 + 14'(i), 4'b1100, {8'(i + 1), 8'h00});
      step();
    end
    chk("ff_5th_dropped", mem_we, 1'b0);
    chk("ff_ready_back", cpu_wr_ready, 1'b1);

    // Read after write, aligned
    cpu_wr_valid = 1'b1; cpu_wr_addr = 16'h0002; cpu_wr_data = 8'h3E;
    step();
    cpu_wr_valid = 1'b0;
    cpu_rd_req = 1'b1; cpu_rd_addr = 16'h0002;
    #1;
    chk("raw_blocked", cpu_rd_ready, 1'b0);
    op("raw_wr", 14'h0000, 4'b0011, 16'h003E);
    step();
    chk("raw_ready", cpu_rd_ready, 1'b1);
    step();
    cpu_rd_req = 1'b0;
    #1;
    chk("raw_op_we", mem_we, 1'b0);
    chk("raw_op_addr", mem_addr, 14'h0000);
    chk("raw_op_state", state_dbg, 3'd2);
    chk("raw_busy", cpu_rd_ready, 1'b0);
    step();
    chk("raw_wait_valid", cpu_rd_valid, 1'b0);
    step();
    chk("raw_valid", cpu_rd_valid, 1'b1);
    chk("raw_data", cpu_rd_data, 8'h3E);
    step();
    chk("raw_pulse", cpu_rd_valid, 1'b0);
    chk("raw_hold", cpu_rd_data, 8'h3E);

    // Split write then split read
    wr(16'h0003, 8'h9D);
    cpu_rd_req = 1'b1; cpu_rd_addr = 16'h0003;
    #1;
    chk("srd_blk1", cpu_rd_ready, 1'b0);
    op("srd_wA", 14'h0000, 4'b0001, 16'h0009);
    step();
    chk("srd_blk2", cpu_rd_ready, 1'b0);
    op("srd_wB", 14'h0001, 4'b1000, 16'hD000);
    step();
    chk("srd_ready", cpu_rd_ready, 1'b1);
    step();
    cpu_rd_req = 1'b0;
    #1;
    chk("srd_opA", mem_addr, 14'h0000);
    step();
    chk("srd_opB", mem_addr, 14'h0001);
    chk("srd_stB", state_dbg, 3'd3);
    step();
    chk("srd_wait", cpu_rd_valid, 1'b0);
    step();
    chk("srd_valid", cpu_rd_valid, 1'b1);
    chk("srd_data", cpu_rd_data, 8'h9D);

    // Reset between split halves with a second write queued
    vid_req = 1'b1; vid_addr = 14'h105;
    wr(16'h000B, 8'hEE);
    wr(16'h0030, 8'h66);
    vid_req = 1'b0;
    #1;
    op("rsA", 14'h0002, 4'b0001, 16'h000E);
    step();
    chk("rs_state_b", state_dbg, 3'd1);
    reset = 1'b1;
    #1;
    chk("rs_we", mem_we, 1'b0);
    chk("rs_wr_ready", cpu_wr_ready, 1'b1);
    chk("rs_rd_ready", cpu_rd_ready, 1'b1);
    chk("rs_state", state_dbg, 3'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rs_noB_1", mem_we, 1'b0);
    step();
    chk("rs_noB_2", mem_we, 1'b0);

    // Reset with a read in flight
    cpu_rd_req = 1'b1; cpu_rd_addr = 16'h0010;
    #1;
    chk("rr_ready", cpu_rd_ready, 1'b1);
    step();
    cpu_rd_req = 1'b0;
    vid_req = 1'b1; vid_addr = 14'h106;
    #1;
    chk("rr_vid_addr", mem_addr, 14'h106);
    chk("rr_stall_state", state_dbg, 3'd2);
    step();
    vid_req = 1'b0;
    #1;
    chk("rr_op_addr", mem_addr, 14'h0004);
    step();
    chk("rr_wait_state", state_dbg, 3'd4);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("rr_valid0", cpu_rd_valid, 1'b0);
    chk("rr_data0", cpu_rd_data, 8'h00);
    step();
    chk("rr_valid1", cpu_rd_valid, 1'b0);
    step();
    chk("rr_valid2", cpu_rd_valid, 1'b0);
    chk("rr_ready_back", cpu_rd_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
